// File: rtl/conv_dot25_calc.sv
// conv_dot25_calc: 4-stage pipelined 25-tap fixed-point dot product
// with bias, round-half-up, saturation and optional ReLU.
//
// Ports:
//   clk, rst_n  : clock, async active-low reset
//   valid_i     : data_i carries a window this cycle
//   data_i      : {VecA[25], VecB[25], Bias}, WIDTH bits each
//   clear_i     : sync clear of sat_flag_o (set wins)
//   valid_o     : data_o is a result this cycle
//   data_o      : rounded, saturated result, Q(WIDTH-FRAC).FRAC
//   sat_flag_o  : sticky saturation indicator
module conv_dot25_calc #(
   parameter int WIDTH   = 16,
   parameter int FRAC    = 8,
   parameter bit RELU_EN = 1'b1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                valid_i,
   input  logic [51*WIDTH-1:0] data_i,
   input  logic                clear_i,
   output logic                valid_o,
   output logic [WIDTH-1:0]    data_o,
   output logic                sat_flag_o
);

   localparam int N  = 25;
   localparam int PW = 2 * WIDTH;
   localparam int QW = PW + 3;
   localparam int SW = PW + 5;

   localparam logic signed [SW-1:0] HALF =
      SW'(1) <<< (FRAC - 1);
   localparam logic signed [SW-1:0] MAXV =
      (SW'(1) <<< (WIDTH - 1)) - SW'(1);
   localparam logic signed [SW-1:0] MINV =
      -(SW'(1) <<< (WIDTH - 1));

   // operand unpacking
   logic signed [WIDTH-1:0] op_a [N];
   logic signed [WIDTH-1:0] op_b [N];

   for (genvar g = 0; g < N; g++) begin : g_ops
      assign op_a[g] = data_i[(26 + g) * WIDTH +: WIDTH];
      assign op_b[g] = data_i[(1 + g) * WIDTH +: WIDTH];
   end

   // S1: products
   logic signed [PW-1:0]    prod [N];
   logic signed [WIDTH-1:0] bias1;
   logic                    v1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < N; k++) begin
            prod[k] <= '0;
         end
         bias1 <= '0;
         v1    <= 1'b0;
      end else begin
         for (int k = 0; k < N; k++) begin
            prod[k] <= PW'(op_a[k]) * PW'(op_b[k]);
         end
         bias1 <= data_i[WIDTH-1:0];
         v1    <= valid_i;
      end
   end

   // S2: five partial sums of five products
   logic signed [QW-1:0]    part_n [5];
   logic signed [QW-1:0]    part   [5];
   logic signed [WIDTH-1:0] bias2;
   logic                    v2;

   always_comb begin
      for (int j = 0; j < 5; j++) begin
         part_n[j] = '0;
         for (int i = 0; i < 5; i++) begin
            part_n[j] = part_n[j] + QW'(prod[5*j + i]);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int j = 0; j < 5; j++) begin
            part[j] <= '0;
         end
         bias2 <= '0;
         v2    <= 1'b0;
      end else begin
         for (int j = 0; j < 5; j++) begin
            part[j] <= part_n[j];
         end
         bias2 <= bias1;
         v2    <= v1;
      end
   end

   // S3: final sum, bias aligned to the product binary point
   logic signed [SW-1:0] sum_n;
   logic signed [SW-1:0] sum3;
   logic                 v3;

   always_comb begin
      sum_n = SW'(bias2) <<< FRAC;
      for (int j = 0; j < 5; j++) begin
         sum_n = sum_n + SW'(part[j]);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum3 <= '0;
         v3   <= 1'b0;
      end else begin
         sum3 <= sum_n;
         v3   <= v2;
      end
   end

   // S4: round half toward +inf, saturate, ReLU
   logic signed [SW-1:0] biased;
   logic signed [SW-1:0] rnd;
   logic                 hi;
   logic                 lo;
   logic                 sat;
   logic [WIDTH-1:0]     res;

   always_comb begin
      biased = sum3 + HALF;
      rnd    = biased >>> FRAC;
      hi     = rnd > MAXV;
      lo     = rnd < MINV;
      sat    = hi | lo;
      res    = rnd[WIDTH-1:0];
      if (hi) begin
         res = MAXV[WIDTH-1:0];
      end else if (lo) begin
         res = MINV[WIDTH-1:0];
      end
      // clipping is still reported even when ReLU zeroes it
      if (RELU_EN && res[WIDTH-1]) begin
         res = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_o     <= '0;
         valid_o    <= 1'b0;
         sat_flag_o <= 1'b0;
      end else begin
         data_o  <= res;
         valid_o <= v3;
         if (v3 && sat) begin
            sat_flag_o <= 1'b1;
         end else if (clear_i) begin
            sat_flag_o <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_conv_dot25_calc.sv
// tb_conv_dot25_calc: directed table plus hand sequences for
// conv_dot25_calc, two instances (ReLU off / on) on shared inputs.
module tb_conv_dot25_calc;

   localparam int W  = 16;
   localparam int DW = 51 * W;

   logic          clk     = 1'b0;
   logic          rst_n   = 1'b0;
   logic          valid_i = 1'b0;
   logic          clear_i = 1'b0;
   logic [DW-1:0] data_i  = '0;
   logic          v0, v1, f0, f1;
   logic [W-1:0]  d0, d1;

   always #5 clk = ~clk;

   conv_dot25_calc #(.WIDTH(W), .FRAC(8), .RELU_EN(1'b0)) u0 (
      .clk(clk), .rst_n(rst_n), .valid_i(valid_i),
      .data_i(data_i), .clear_i(clear_i),
      .valid_o(v0), .data_o(d0), .sat_flag_o(f0)
   );

   conv_dot25_calc #(.WIDTH(W), .FRAC(8), .RELU_EN(1'b1)) u1 (
      .clk(clk), .rst_n(rst_n), .valid_i(valid_i),
      .data_i(data_i), .clear_i(clear_i),
      .valid_o(v1), .data_o(d1), .sat_flag_o(f1)
   );

   typedef struct {
      logic [DW-1:0] data;
      logic [W-1:0]  e0;
      logic [W-1:0]  e1;
      logic          s;
   } vec_t;

   vec_t tbl [11];

   int n_chk  = 0;
   int n_pass = 0;

   // expectation pipeline
   logic         m_v  [4];
   logic [W-1:0] m_e0 [4];
   logic [W-1:0] m_e1 [4];
   logic         m_s  [4];
   logic         m_f;
   logic [W-1:0] c_e0, c_e1;
   logic         c_s;

   task automatic chk(input string nm,
                      input logic [W-1:0] act,
                      input logic [W-1:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h want %h", nm, act, exp);
   endtask

   task automatic model_clear();
      for (int i = 0; i < 4; i++) begin
         m_v[i] = 1'b0; m_e0[i] = '0;
         m_e1[i] = '0; m_s[i] = 1'b0;
      end
      m_f = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      if (!rst_n) begin
         model_clear();
      end else begin
         for (int i = 3; i > 0; i--) begin
            m_v[i]  = m_v[i-1];
            m_e0[i] = m_e0[i-1];
            m_e1[i] = m_e1[i-1];
            m_s[i]  = m_s[i-1];
         end
         m_v[0] = valid_i; m_e0[0] = c_e0;
         m_e1[0] = c_e1; m_s[0] = c_s;
         if (m_v[3] && m_s[3]) m_f = 1'b1;
         else if (clear_i) m_f = 1'b0;
      end
      @(negedge clk);
      chk("valid_o relu0", W'(v0), W'(m_v[3]));
      chk("valid_o relu1", W'(v1), W'(m_v[3]));
      if (m_v[3]) begin
         chk("data_o relu0", d0, m_e0[3]);
         chk("data_o relu1", d1, m_e1[3]);
      end
      chk("sat_flag relu0", W'(f0), W'(m_f));
      chk("sat_flag relu1", W'(f1), W'(m_f));
   endtask

   function automatic logic [DW-1:0] uni(
      input logic [W-1:0] a, input logic [W-1:0] b,
      input logic [W-1:0] bias);
      logic [DW-1:0] d;
      for (int k = 0; k < 25; k++) begin
         d[(26 + k) * W +: W] = a;
         d[(1 + k) * W +: W]  = b;
      end
      d[W-1:0] = bias;
      return d;
   endfunction

   function automatic logic [DW-1:0] one(
      input logic [W-1:0] a, input logic [W-1:0] b,
      input logic [W-1:0] bias);
      logic [DW-1:0] d;
      d = '0;
      d[26 * W +: W] = a;
      d[W +: W]      = b;
      d[W-1:0]       = bias;
      return d;
   endfunction

   function automatic void ref_calc(input logic [DW-1:0] d,
      output logic [W-1:0] e0, output logic [W-1:0] e1,
      output logic s);
      longint acc, r;
      logic [W-1:0] a, b, bias;
      acc = 0;
      for (int k = 0; k < 25; k++) begin
         a = d[(26 + k) * W +: W];
         b = d[(1 + k) * W +: W];
         acc += longint'($signed(a)) * longint'($signed(b));
      end
      bias = d[W-1:0];
      acc += longint'($signed(bias)) * 256;
      r = (acc + 128) >>> 8;
      s = 1'b0;
      if (r > 32767) begin r = 32767; s = 1'b1; end
      else if (r < -32768) begin r = -32768; s = 1'b1; end
      e0 = r[W-1:0];
      e1 = (r < 0) ? '0 : r[W-1:0];
   endfunction

   task automatic load(input vec_t v);
      data_i = v.data; c_e0 = v.e0;
      c_e1 = v.e1; c_s = v.s;
   endtask

   task automatic rand_load();
      logic [DW-1:0] d;
      logic [9:0]    t;
      logic [W-1:0]  e0, e1;
      logic          s;
      for (int k = 1; k < 51; k++) begin
         t = 10'($urandom);
         d[k * W +: W] = {{6{t[9]}}, t};
      end
      d[W-1:0] = W'($urandom);
      ref_calc(d, e0, e1, s);
      data_i = d; c_e0 = e0; c_e1 = e1; c_s = s;
   endtask

   initial begin
      tbl[0]  = '{uni(16'h0100, 16'h0100, 16'h0000),
                  16'h1900, 16'h1900, 1'b0};
      tbl[1]  = '{uni(16'h0100, 16'hFF00, 16'h0080),
                  16'hE780, 16'h0000, 1'b0};
      tbl[2]  = '{one(16'h0001, 16'h0080, 16'h0000),
                  16'h0001, 16'h0001, 1'b0};
      tbl[3]  = '{one(16'h0001, 16'h007F, 16'h0000),
                  16'h0000, 16'h0000, 1'b0};
      tbl[4]  = '{uni(16'h7FFF, 16'h7FFF, 16'h0000),
                  16'h7FFF, 16'h7FFF, 1'b1};
      tbl[5]  = '{uni(16'h7FFF, 16'h8000, 16'h0000),
                  16'h8000, 16'h0000, 1'b1};
      tbl[6]  = '{one(16'h0000, 16'h0000, 16'hFF80),
                  16'hFF80, 16'h0000, 1'b0};
      tbl[7]  = '{one(16'h0001, 16'hFF80, 16'h0000),
                  16'h0000, 16'h0000, 1'b0};
      tbl[8]  = '{one(16'h0000, 16'h0000, 16'h7FFF),
                  16'h7FFF, 16'h7FFF, 1'b0};
      tbl[9]  = '{one(16'h0001, 16'h0080, 16'h7FFF),
                  16'h7FFF, 16'h7FFF, 1'b1};
      tbl[10] = '{one(16'h0000, 16'h0000, 16'h8000),
                  16'h8000, 16'h0000, 1'b0};

      model_clear();
      c_e0 = '0; c_e1 = '0; c_s = 1'b0;

      // reset state
      tick();
      tick();
      chk("reset data_o", d0, 16'h0000);
      rst_n = 1'b1;

      // table: isolated windows, latency and values
      for (int i = 0; i < 11; i++) begin
         load(tbl[i]);
         valid_i = 1'b1;
         tick();
         valid_i = 1'b0;
         repeat (4) tick();
      end

      // sticky through a non-saturating sample
      load(tbl[0]);
      valid_i = 1'b1;
      tick();
      valid_i = 1'b0;
      repeat (4) tick();
      chk("sticky flag", W'(f0), 16'h0001);

      // clear pulse
      clear_i = 1'b1;
      tick();
      clear_i = 1'b0;
      chk("flag after clear", W'(f0), 16'h0000);

      // clear coincident with a saturating output
      load(tbl[4]);
      valid_i = 1'b1;
      tick();
      valid_i = 1'b0;
      tick();
      tick();
      clear_i = 1'b1;
      tick();
      clear_i = 1'b0;
      chk("set beats clear", W'(f0), 16'h0001);
      chk("set beats clear valid", W'(v0), 16'h0001);

      // streaming 10, gap 2, 3 more
      valid_i = 1'b1;
      for (int i = 0; i < 10; i++) begin
         rand_load();
         tick();
      end
      valid_i = 1'b0;
      repeat (2) tick();
      valid_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         rand_load();
         tick();
      end
      valid_i = 1'b0;
      repeat (5) tick();

      // reset with three samples in flight
      load(tbl[4]);
      valid_i = 1'b1;
      repeat (3) tick();
      valid_i = 1'b0;
      rst_n = 1'b0;
      model_clear();
      #1;
      chk("rst valid_o", W'(v0), 16'h0000);
      chk("rst data_o relu0", d0, 16'h0000);
      chk("rst data_o relu1", d1, 16'h0000);
      chk("rst sat_flag", W'(f0), 16'h0000);
      tick();
      rst_n = 1'b1;
      load(tbl[1]);
      valid_i = 1'b1;
      tick();
      valid_i = 1'b0;
      repeat (6) tick();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
